// File: rtl/xmbox.sv
// xmbox: bus-mapped mailbox between the controller data bus and a pair of
// valid/ready streams. CPU writes to TXDATA feed the tx stream through a
// small FIFO; rx stream words are buffered and popped by CPU reads of RXDATA.
module xmbox #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] tx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [DATA_W-1:0] rx_data
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);

    logic [DATA_W-1:0]     tx_mem [DEPTH];
    logic [DATA_W-1:0]     rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    logic [DEPTH_LOG2:0]   tx_level, rx_level;
    logic                  tx_ovf, rx_unf;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_hit, tx_push, tx_pop, tx_flush;
    logic rx_hit, rx_push, rx_pop, rx_flush;
    logic ctrl_wr, flag_clr;
    logic [7:0] tx_lvl8, rx_lvl8;
    logic [DATA_W-1:0] status;

    // Decode bus strobes and stream handshakes
    always_comb begin
        tx_full  = (tx_level == LVL_FULL);
        tx_empty = (tx_level == '0);
        rx_full  = (rx_level == LVL_FULL);
        rx_empty = (rx_level == '0);

        tx_valid = ~tx_empty;
        tx_data  = tx_mem[tx_rd_ptr];
        rx_ready = ~rx_full & rst;

        ctrl_wr  = sel & we & (addr == 2'd3);
        tx_flush = ctrl_wr & data_in[0];
        rx_flush = ctrl_wr & data_in[1];
        flag_clr = ctrl_wr & data_in[2];

        tx_hit   = sel & we & (addr == 2'd0);
        tx_push  = tx_hit & ~tx_full;
        tx_pop   = tx_valid & tx_ready;

        rx_hit   = sel & ~we & (addr == 2'd1);
        rx_pop   = rx_hit & ~rx_empty;
        rx_push  = rx_valid & rx_ready;
    end

    // Assemble STATUS word
    always_comb begin
        tx_lvl8 = '0;
        rx_lvl8 = '0;
        tx_lvl8[DEPTH_LOG2:0] = tx_level;
        rx_lvl8[DEPTH_LOG2:0] = rx_level;
        status        = '0;
        status[0]     = tx_full;
        status[1]     = tx_empty;
        status[2]     = rx_full;
        status[3]     = rx_empty;
        status[4]     = tx_ovf;
        status[5]     = rx_unf;
        status[15:8]  = tx_lvl8;
        status[23:16] = rx_lvl8;
    end

    // Zero-wait read mux; anything not a selected read returns zero
    always_comb begin
        data_out = '0;
        if (sel && !we) begin
            case (addr)
                2'd1:    data_out = rx_empty ? '0 : rx_mem[rx_rd_ptr];
                2'd2:    data_out = status;
                default: data_out = '0;
            endcase
        end
    end

    // FIFO storage (not reset; contents are only visible through pointers)
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= data_in;
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
    end

    // TX pointers, level and overflow flag; flush overrides push/pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_level  <= '0;
            tx_ovf    <= 1'b0;
        end else begin
            if (flag_clr)                tx_ovf <= 1'b0;
            else if (tx_hit && tx_full)  tx_ovf <= 1'b1;
            if (tx_flush) begin
                tx_wr_ptr <= '0;
                tx_rd_ptr <= '0;
                tx_level  <= '0;
            end else begin
                if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
                if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
                if (tx_push && !tx_pop)      tx_level <= tx_level + LVL_ONE;
                else if (tx_pop && !tx_push) tx_level <= tx_level - LVL_ONE;
            end
        end
    end

    // RX pointers, level and underflow flag; a word taken during flush is discarded
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_level  <= '0;
            rx_unf    <= 1'b0;
        end else begin
            if (flag_clr)                rx_unf <= 1'b0;
            else if (rx_hit && rx_empty) rx_unf <= 1'b1;
            if (rx_flush) begin
                rx_wr_ptr <= '0;
                rx_rd_ptr <= '0;
                rx_level  <= '0;
            end else begin
                if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
                if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
                if (rx_push && !rx_pop)      rx_level <= rx_level + LVL_ONE;
                else if (rx_pop && !rx_push) rx_level <= rx_level - LVL_ONE;
            end
        end
    end

endmodule
